// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 scan-code receiver:
//   - ps2_state_e  : frame FSM states (IDLE, DATA, PARITY, STOP)
//   - PS2_BREAK    : break prefix byte (0xF0)
//   - PS2_EXT      : extended prefix byte (0xE0)
//   - PS2_DATA_BITS: data bits per frame
//   - parityOk()   : odd-parity check over data byte plus parity bit
// ---------------------------------------------------------------------------
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_BREAK     = 8'hF0;
  localparam logic [7:0] PS2_EXT       = 8'hE0;
  localparam int         PS2_DATA_BITS = 8;

  // PS/2 uses odd parity: data bits plus parity bit must hold an odd count of ones.
  function automatic logic parityOk(input logic [7:0] i_byte, input logic i_par);
    return ^{i_byte, i_par};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ---------------------------------------------------------------------------
// ps2_line_filter
// Conditions the raw PS/2 lines for the frame decoder: two-flop synchronizers
// on clock and data, a glitch filter on the clock, and a falling-edge detector
// producing a one-cycle sample event together with the data bit to capture.
//
// Parameters:
//   FILTER_LEN - consecutive equal synchronized samples needed before the
//                filtered clock level changes
// Ports:
//   clk        - system clock (rising edge)
//   reset_n    - asynchronous active-low reset (lines reset to idle-high)
//   i_ps2Clk   - raw keyboard clock
//   i_ps2Data  - raw keyboard data
//   o_sample   - one-cycle pulse on a filtered-clock 1->0 transition
//   o_data     - synchronized data captured in the cycle of the transition
// ---------------------------------------------------------------------------
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_ps2Clk,
  input  logic i_ps2Data,
  output logic o_sample,
  output logic o_data
);

  localparam int FLT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);

  logic [1:0]       r_clkSync;
  logic [1:0]       r_dataSync;
  logic             r_filtClk;
  logic [FLT_W-1:0] r_filtCnt;
  logic             r_sample;
  logic             r_sampleData;

  // The counter tracks how long the synchronized clock has disagreed with the
  // filtered level; any agreeing sample restarts it, so short glitches vanish.
  // The FILTER_LEN-th disagreeing sample flips the level, and a 1->0 flip
  // raises the sample event with the data bit synchronized alongside it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clkSync    <= 2'b11;
      r_dataSync   <= 2'b11;
      r_filtClk    <= 1'b1;
      r_filtCnt    <= '0;
      r_sample     <= 1'b0;
      r_sampleData <= 1'b1;
    end else begin
      r_clkSync  <= {r_clkSync[0], i_ps2Clk};
      r_dataSync <= {r_dataSync[0], i_ps2Data};
      r_sample   <= 1'b0;
      if (r_clkSync[1] == r_filtClk) begin
        r_filtCnt <= '0;
      end else if (r_filtCnt == FLT_LAST) begin
        r_filtClk <= r_clkSync[1];
        r_filtCnt <= '0;
        if (r_filtClk) begin
          r_sample     <= 1'b1;
          r_sampleData <= r_dataSync[1];
        end
      end else begin
        r_filtCnt <= r_filtCnt + 1'b1;
      end
    end
  end

  assign o_sample = r_sample;
  assign o_data   = r_sampleData;

endmodule

// File: rtl/ps2_scancode_rx.sv
// ---------------------------------------------------------------------------
// ps2_scancode_rx
// PS/2 keyboard receiver: deframes 11-bit PS/2 frames (start, 8 data LSB
// first, parity, stop) and turns the byte stream into make codes. The 0xF0
// break prefix suppresses the next code; the 0xE0 prefix marks it extended.
// A per-frame watchdog abandons frames whose clock stops.
//
// Configuration macro:
//   PS2_PARITY_CHECK_EN - when defined, frames failing odd parity are
//                         rejected with frame_err; otherwise the parity bit
//                         is sampled and ignored.
// Parameters:
//   FILTER_LEN     - glitch filter length on ps2_clk (system clocks)
//   TIMEOUT_CYCLES - idle clocks allowed between falling edges in a frame
// Ports:
//   clk        - system clock (rising edge)
//   reset_n    - asynchronous active-low reset
//   ps2_clk    - raw keyboard clock
//   ps2_data   - raw keyboard data
//   code       - last accepted make code, held between pulses
//   code_valid - one-cycle pulse, code/extended valid in that cycle
//   extended   - emitted code was preceded by 0xE0
//   frame_err  - one-cycle pulse on stop, parity or timeout error
// ---------------------------------------------------------------------------
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       extended,
  output logic       frame_err
);

  localparam int BIT_W = $clog2(PS2_DATA_BITS);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PS2_DATA_BITS - 1);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic w_sample;
  logic w_data;
  logic w_parityOk;

  ps2_state_e       r_state;
  logic [BIT_W-1:0] r_bitCnt;
  logic [TO_W-1:0]  r_toCnt;
  logic [7:0]       r_shift;
  logic             r_parity;
  logic             r_brk;
  logic             r_ext;
  logic [7:0]       r_code;
  logic             r_codeValid;
  logic             r_extended;
  logic             r_frameErr;

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_lineFilter (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_ps2Clk (ps2_clk),
    .i_ps2Data(ps2_data),
    .o_sample (w_sample),
    .o_data   (w_data)
  );

`ifdef PS2_PARITY_CHECK_EN
  assign w_parityOk = parityOk(r_shift, r_parity);
`else
  // Parity is still captured so framing is identical; its verdict is discarded.
  assign w_parityOk = parityOk(r_shift, r_parity) | 1'b1;
`endif

  // Frame FSM, prefix tracking and watchdog share one block so that a sample
  // event and a timeout in the same cycle resolve in favour of the sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_bitCnt    <= '0;
      r_toCnt     <= '0;
      r_shift     <= '0;
      r_parity    <= 1'b0;
      r_brk       <= 1'b0;
      r_ext       <= 1'b0;
      r_code      <= 8'h00;
      r_codeValid <= 1'b0;
      r_extended  <= 1'b0;
      r_frameErr  <= 1'b0;
    end else begin
      r_codeValid <= 1'b0;
      r_frameErr  <= 1'b0;
      if (w_sample) begin
        r_toCnt <= '0;
        case (r_state)
          DATA: begin
            r_shift  <= {w_data, r_shift[7:1]};
            r_bitCnt <= r_bitCnt + 1'b1;
            if (r_bitCnt == BIT_LAST) begin
              r_state <= PARITY;
            end
          end
          PARITY: begin
            r_parity <= w_data;
            r_state  <= STOP;
          end
          STOP: begin
            r_state <= IDLE;
            if (w_data && w_parityOk) begin
              if (r_shift == PS2_BREAK) begin
                r_brk <= 1'b1;
              end else if (r_shift == PS2_EXT) begin
                r_ext <= 1'b1;
              end else begin
                if (!r_brk) begin
                  r_codeValid <= 1'b1;
                  r_code      <= r_shift;
                  r_extended  <= r_ext;
                end
                r_brk <= 1'b0;
                r_ext <= 1'b0;
              end
            end else begin
              r_frameErr <= 1'b1;
              r_brk      <= 1'b0;
              r_ext      <= 1'b0;
            end
          end
          // IDLE and any unexpected encoding: wait for a start bit.
          default: begin
            if (!w_data) begin
              r_state  <= DATA;
              r_bitCnt <= '0;
            end else begin
              r_state <= IDLE;
            end
          end
        endcase
      end else if (r_state != IDLE) begin
        if (r_toCnt == TO_LAST) begin
          r_state    <= IDLE;
          r_bitCnt   <= '0;
          r_toCnt    <= '0;
          r_frameErr <= 1'b1;
          r_brk      <= 1'b0;
          r_ext      <= 1'b0;
        end else begin
          r_toCnt <= r_toCnt + 1'b1;
        end
      end
    end
  end

  assign code       = r_code;
  assign code_valid = r_codeValid;
  assign extended   = r_extended;
  assign frame_err  = r_frameErr;

endmodule
